// File: rtl/scd_pkg.sv
// Shared definitions for the SCD datapath: SCAD function codes, trap FSM states,
// flag and mode bit positions.
package scd_pkg;

  typedef enum logic [2:0] {
    FN_ADD = 3'd0,
    FN_SUB = 3'd1,
    FN_A   = 3'd2,
    FN_B   = 3'd3,
    FN_INC = 3'd4,
    FN_DEC = 3'd5,
    FN_AND = 3'd6,
    FN_OR  = 3'd7
  } scad_fn_e;

  typedef enum logic [1:0] {
    TRAP_IDLE = 2'd0,
    TRAP_CYC1 = 2'd1,
    TRAP_CYC2 = 2'd2
  } trap_state_e;

  // Flag vector is {OV,CRY0,CRY1,FOV,FXU,FPD,DIV_CHK}; leftmost field is bit 0 (MSB).
  localparam int FLG_OV      = 6;
  localparam int FLG_CRY0    = 5;
  localparam int FLG_CRY1    = 4;
  localparam int FLG_FOV     = 3;
  localparam int FLG_FXU     = 2;
  localparam int FLG_FPD     = 1;
  localparam int FLG_DIV_CHK = 0;

  // Mode vector is {USER,USER_IOT,PUBLIC,PRIVATE,PCP}.
  localparam int MODE_USER     = 4;
  localparam int MODE_USER_IOT = 3;
  localparam int MODE_PUBLIC   = 2;
  localparam int MODE_PRIVATE  = 1;
  localparam int MODE_PCP      = 0;

  // Flags whose 0->1 transition raises trap request 1.
  localparam logic [6:0] TRAP1_FLG_MASK = 7'b1001001;

  localparam logic [9:0] SC_LIMIT = 10'd36;

  function automatic logic [35:0] sext36(input logic [9:0] v);
    return {{26{v[9]}}, v};
  endfunction

endpackage

// File: rtl/scd_adder.sv
// SCAD: 10-bit combinational shift-count adder/logic unit, result wraps mod 1024.
module scd_adder
  import scd_pkg::*;
(
  input  logic [9:0] a,
  input  logic [9:0] b,
  input  logic [2:0] fn,
  output logic [9:0] result
);

  always_comb begin
    result = '0;
    case (fn)
      FN_ADD: result = a + b;
      FN_SUB: result = a - b;
      FN_A:   result = a;
      FN_B:   result = b;
      FN_INC: result = a + 10'd1;
      FN_DEC: result = a - 10'd1;
      FN_AND: result = a & b;
      FN_OR:  result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/scd_datapath.sv
// SCD datapath: SCAD, FE/SC registers, processor flags and mode, address-break
// prevent and the two-level trap request/cycle sequencer.
module scd_datapath
  import scd_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  scada_in,
  input  logic [9:0]  scadb_in,
  input  logic [2:0]  scad_fn,
  input  logic        fe_load,
  input  logic        sc_load,
  input  logic        sc_sel_armm,
  input  logic        sc_dec,
  input  logic [13:0] armm,
  input  logic [6:0]  flg_in,
  input  logic        flg_set,
  input  logic        flg_load,
  input  logic [4:0]  mode_in,
  input  logic        pdl_ov,
  input  logic        trap_take,
  input  logic        trap_done,
  input  logic        abk_set,
  output logic [35:0] scada,
  output logic [35:0] scadb,
  output logic [9:0]  scad,
  output logic        scad_eq0,
  output logic        scad_sign,
  output logic        cry0,
  output logic [9:0]  fe,
  output logic        fe_sign,
  output logic [9:0]  sc,
  output logic        sc_sign,
  output logic        sc_ge_36,
  output logic [8:0]  armm_upper,
  output logic [4:0]  armm_lower,
  output logic [6:0]  flags,
  output logic [4:0]  mode,
  output logic        trap_req1,
  output logic        trap_req2,
  output logic        trap_cyc1,
  output logic        trap_cyc2,
  output logic        adr_brk_prevent
);

  logic [9:0]  scad_r;
  logic [9:0]  fe_q, sc_q;
  logic [6:0]  flags_q;
  logic [4:0]  mode_q;
  logic        req1_q, req2_q, abk_q;
  logic        take_req1, take_req2, flg_rise;
  trap_state_e state_q, state_d;

  scd_adder u_adder (
    .a      (scada_in),
    .b      (scadb_in),
    .fn     (scad_fn),
    .result (scad_r)
  );

  assign scad       = scad_r;
  assign scad_eq0   = (scad_r == 10'd0);
  assign scad_sign  = scad_r[9];
  assign scada      = sext36(scada_in);
  assign scadb      = sext36(scadb_in);
  assign armm_upper = armm[13:5];
  assign armm_lower = armm[4:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     fe_q <= '0;
    else if (fe_load) fe_q <= scad_r;
  end

  // Decrementing from 10'h200 naturally wraps to 10'h1FF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     sc_q <= '0;
    else if (sc_load) sc_q <= sc_sel_armm ? {5'd0, armm[4:0]} : scad_r;
    else if (sc_dec)  sc_q <= sc_q - 10'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
      mode_q  <= '0;
    end else if (flg_load) begin
      flags_q <= flg_in;
      mode_q  <= mode_in;
    end else if (flg_set) begin
      flags_q <= flags_q | flg_in;
    end
  end

  // Only a genuine 0->1 set of OV/FOV/DIV_CHK outside PCP mode requests a trap.
  assign flg_rise = flg_set && !flg_load && !mode_q[MODE_PCP] &&
                    ((flg_in & ~flags_q & TRAP1_FLG_MASK) != 7'd0);

  // A new request arriving in the same cycle as its take-clear survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req1_q <= 1'b0;
      req2_q <= 1'b0;
    end else begin
      req1_q <= flg_rise | (req1_q & ~take_req1);
      req2_q <= pdl_ov   | (req2_q & ~take_req2);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   abk_q <= 1'b0;
    else if (abk_set)               abk_q <= 1'b1;
    else if (trap_done || flg_load) abk_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= TRAP_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TRAP_IDLE: if (trap_take) begin
        if (req2_q)      state_d = TRAP_CYC2;
        else if (req1_q) state_d = TRAP_CYC1;
      end
      TRAP_CYC1,
      TRAP_CYC2: if (trap_done) state_d = TRAP_IDLE;
      default:   state_d = TRAP_IDLE;
    endcase
  end

  always_comb begin
    trap_cyc1 = (state_q == TRAP_CYC1);
    trap_cyc2 = (state_q == TRAP_CYC2);
    take_req2 = (state_q == TRAP_IDLE) && trap_take && req2_q;
    take_req1 = (state_q == TRAP_IDLE) && trap_take && !req2_q && req1_q;
  end

  assign fe              = fe_q;
  assign fe_sign         = fe_q[9];
  assign sc              = sc_q;
  assign sc_sign         = sc_q[9];
  assign sc_ge_36        = !sc_q[9] && (sc_q >= SC_LIMIT);
  assign flags           = flags_q;
  assign cry0            = flags_q[FLG_CRY0];
  assign mode            = mode_q;
  assign trap_req1       = req1_q;
  assign trap_req2       = req2_q;
  assign adr_brk_prevent = abk_q;

endmodule

// File: doc/scd_datapath.md
SCD_DATAPATH -- requirements
Module: scd_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 RESET_N  in  1  asynchronous active-low reset.
REQ-004 SCADA_IN  in  10  SCAD A operand (two's complement).
REQ-005 SCADB_IN  in  10  SCAD B operand (two's complement).
REQ-006 SCAD_FN  in  3  function: 0 A+B, 1 A-B, 2 A, 3 B, 4 A+1, 5 A-1, 6 A&B, 7 A|B.
REQ-007 FE_LOAD  in  1  FE <= SCAD result.
REQ-008 SC_LOAD  in  1  SC <= SCAD result, or ARMM_LOWER when SC_SEL_ARMM=1.
REQ-009 SC_SEL_ARMM  in  1  SC load source select.
REQ-010 SC_DEC  in  1  SC <= SC-1 (shift-loop count).
REQ-011 ARMM  in  14  {upper[0:8], lower[13:17]}, passed to SCD.ARMM_UPPER/ARMM_LOWER.
REQ-012 FLG_IN  in  7  {OV,CRY0,CRY1,FOV,FXU,FPD,DIV_CHK}.
REQ-013 FLG_SET  in  1  OR FLG_IN into flags.
REQ-014 FLG_LOAD  in  1  replace flags and mode with FLG_IN/MODE_IN.
REQ-015 MODE_IN  in  5  {USER,USER_IOT,PUBLIC,PRIVATE,PCP}.
REQ-016 PDL_OV  in  1  pushdown-overflow pulse.
REQ-017 TRAP_TAKE  in  1  microcode starts trap cycle.
REQ-018 TRAP_DONE  in  1  microcode ends trap cycle.
REQ-019 ABK_SET  in  1  set address-break-prevent; cleared by TRAP_DONE or FLG_LOAD.
REQ-020 SCD  iSCD bundle  out  block drives every field of the SCD bundle.

Function
REQ-021 SCAD result SHALL be combinational, 10 bits, wrapping mod 1024; SCADA/SCADB outputs = operands sign-extended to 36 bits.
REQ-022 SCADeq0 = (result==0); SCAD_SIGN = result bit 0; CRY0 side output unaffected by SCAD.
REQ-023 FE/SC SHALL update one cycle after strobe; FE_SIGN/SC_SIGN = bit 0 of register.
REQ-024 SC priority: SC_LOAD over SC_DEC; SC_DEC at 10'h200 wraps to 10'h1FF.
REQ-025 SC_GE_36 = !SC_SIGN && SC>=36, registered-value based.
REQ-026 Flags: FLG_LOAD over FLG_SET; both update next edge.
REQ-027 TRAP_REQ1 SHALL set on the edge where OV, FOV or DIV_CHK goes 0->1 via FLG_SET, only when PCP=0.
REQ-028 TRAP_REQ2 SHALL set on PDL_OV.
REQ-029 Trap FSM states IDLE, CYC1, CYC2; TRAP_CYC1/TRAP_CYC2 asserted in CYC1/CYC2.
REQ-030 IDLE+TRAP_TAKE: REQ2 set -> CYC2 clearing REQ2; else REQ1 set -> CYC1 clearing REQ1; neither -> stay IDLE.
REQ-031 CYCn+TRAP_DONE -> IDLE; TRAP_TAKE in CYCn ignored; new requests during CYCn latch.
REQ-032 Simultaneous request set and clear of same bit: set wins.

Reset
REQ-033 RESET_N low SHALL immediately force FE=SC=0, all flags, mode, TRAP_REQ1/2, ADR_BRK_PREVENT = 0, FSM = IDLE, including mid-trap.

Structure
REQ-034 SCAD_FN encodings, trap FSM state enum and flag bit indices SHALL live in shared package scd_pkg.
REQ-035 The SCAD adder SHALL be sub-module scd_adder (pure combinational); rest is in scd_datapath.

Verification
REQ-036 A=10'h005, B=10'h3FE, FN=0, FE_LOAD -> FE=10'h003, SCADeq0=0, SCAD_SIGN=0.
REQ-037 SC_LOAD A=40 FN=2, then 5 SC_DEC -> SC=35, SC_GE_36 1 then 0 after 5th decrement.
REQ-038 FLG_SET OV with PCP=0 -> TRAP_REQ1=1; TRAP_TAKE -> TRAP_CYC1, REQ1=0; TRAP_DONE -> IDLE.
REQ-039 PDL_OV and OV same cycle, TRAP_TAKE -> CYC2 first, REQ1 still 1; second take -> CYC1.
REQ-040 RESET_N low during CYC2 with FE=10'h123 -> FE=0, TRAP_CYC2=0 without clock edge.
